// File: rtl/mix_unmixer.sv
// Iterative inverse of the eight-lane 32-bit mixing round.
// One lane-step per clock through a single shared multiply/xor/subtract path.
//
// state | meaning
// IDLE  | waiting for a mixed state, in_ready high
// RUN   | one inverse lane-step per cycle, lane 7 down to 0, ROUNDS times
// DONE  | recovered state held on out_data until out_ready
module mix_unmixer #(
  parameter int ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] lane [8];
  logic [2:0]  lane_cnt;
  logic [3:0]  round_cnt;

  logic [31:0] cur, nbr3, nbr7, minv, prod, step_out;

  // Lane indices wrap naturally in the 3-bit counter arithmetic.
  always_comb begin
    cur      = lane[lane_cnt];
    nbr3     = lane[lane_cnt + 3'd3];
    nbr7     = lane[lane_cnt + 3'd7];
    minv     = lane_cnt[0] ? 32'hCCCC_CCCD : 32'hAAAA_AAAB;
    prod     = cur * minv;
    step_out = (prod ^ {nbr3[15:0], 16'h0000}) - nbr7;
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 8; k++) out_data[32*k +: 32] = lane[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      lane_cnt  <= '0;
      round_cnt <= '0;
      for (int k = 0; k < 8; k++) lane[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 8; k++) lane[k] <= in_data[32*k +: 32];
            lane_cnt  <= 3'd7;
            round_cnt <= 4'(ROUNDS - 1);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          lane[lane_cnt] <= step_out;
          lane_cnt       <= lane_cnt - 3'd1;
          if (lane_cnt == 3'd0) begin
            if (round_cnt == 4'd0) begin
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              round_cnt <= round_cnt - 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_unmixer.sv
// Randomized round-trip bench: a forward-mixing model feeds the unmixer and
// the recovered state must match the original.
module tb_mix_unmixer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0] in_data, out_data;
  logic         in1_valid, in1_ready, out1_valid, out1_ready, busy1;
  logic [255:0] in1_data, out1_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_unmixer #(.ROUNDS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  mix_unmixer #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd_state();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Forward mixing rounds written straight from the round definition.
  function automatic logic [255:0] fwd(input logic [255:0] x, input int rounds);
    logic [31:0]  o [8];
    logic [255:0] r;
    for (int k = 0; k < 8; k++) o[k] = x[32*k +: 32];
    for (int rr = 0; rr < rounds; rr++)
      for (int i = 0; i < 8; i++)
        o[i] = ((o[i] + o[(i+7)%8]) ^ (o[(i+3)%8] << 16)) * ((i % 2 == 1) ? 32'd5 : 32'd3);
    for (int k = 0; k < 8; k++) r[32*k +: 32] = o[k];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [255:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd_state();
  endtask

  task automatic wait_out(output int lat, output int busy_n);
    lat = 0;
    busy_n = int'(busy);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      busy_n += int'(busy);
    end
  endtask

  task automatic run_one(input logic [255:0] orig, input int max_stall);
    int lat, bn, stall;
    logic [255:0] cap;
    accept(fwd(orig, 4));
    wait_out(lat, bn);
    check("latency", lat, 32);
    check("busy_cycles", bn, 32);
    check("roundtrip", out_data, orig);
    cap = out_data;
    stall = $urandom_range(0, max_stall);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, cap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  initial begin
    logic [255:0] orig, v1;
    logic [255:0] origs [4];
    logic [255:0] expq [$];
    int lat, bn, n, accepts, outs, last_acc, cyc, seen_valid;
    bit pending;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in1_valid = 1'b0; out1_ready = 1'b1; in1_data = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst1_in_ready", in1_ready, 1);

    // ROUNDS=1 known vector
    v1 = {32'h00E1C5C1, 32'h0000278D, 32'h000F0D2F, 32'd675, 32'd225, 32'd45, 32'd15, 32'd3};
    check("r1_model", fwd(256'd1, 1), v1);
    in1_valid = 1'b1; in1_data = v1;
    @(negedge clk);
    in1_valid = 1'b0; in1_data = rnd_state();
    n = 0;
    while (!out1_valid && n < 50) begin @(negedge clk); n++; end
    check("r1_latency", n, 8);
    check("r1_data", out1_data, 256'd1);

    // All-zero input
    run_one('0, 0);

    // Random round trips with stalls
    for (int t = 0; t < 200; t++) run_one(rnd_state(), 3);

    // Backpressure in DONE
    orig = rnd_state();
    accept(fwd(orig, 4));
    wait_out(lat, bn);
    for (int s = 0; s < 10; s++) begin
      in_valid = 1'b1;
      in_data  = rnd_state();
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, orig);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", out_valid, 0);

    // Reset in the middle of RUN
    accept(fwd(rnd_state(), 4));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    seen_valid = 0;
    repeat (40) begin @(negedge clk); seen_valid |= int'(out_valid); end
    check("mid_rst_no_pulse", seen_valid, 0);
    run_one(rnd_state(), 2);

    // Continuous in_valid with out_ready high
    for (int k = 0; k < 4; k++) origs[k] = rnd_state();
    accepts = 0; outs = 0; last_acc = 0; cyc = 0; pending = 1'b0;
    in_valid = 1'b1; in_data = fwd(origs[0], 4); out_ready = 1'b1;
    while (outs < 4 && cyc < 400) begin
      if (pending) begin
        pending = 1'b0;
        if (accepts < 4) in_data = fwd(origs[accepts], 4);
        else in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() > 0) check("stream_data", out_data, expq.pop_front());
        else check("stream_extra_output", 1, 0);
        outs++;
      end
      if (in_valid && in_ready) begin
        if (accepts > 0) check("stream_gap", cyc - last_acc, 34);
        last_acc = cyc;
        expq.push_back(origs[accepts]);
        accepts++;
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_outputs", outs, 4);
    check("stream_accepts", accepts, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
